// File: rtl/alu_seq_pkg.sv
// Shared opcode set of the lab ALU family plus the sequencer state type for alu_seq.
package OpCodeEnum;

    typedef enum logic [3:0] {
        Add    = 4'd0,
        Sub    = 4'd1,
        And    = 4'd2,
        Or     = 4'd3,
        Xor    = 4'd4,
        LShift = 4'd5,
        RShift = 4'd6,
        Mult   = 4'd7,
        Div    = 4'd8,
        Mod    = 4'd9
    } OpCode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per clock for N clocks.
// Quotient/remainder outputs are the values of the current step, so done marks the step whose outputs are final.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  r_reg;
    logic [N-1:0]  b_reg;
    logic [N:0]    partial;
    logic          fits;

    always_comb begin
        partial   = {r_reg, q_reg[N-1]};
        fits      = (partial >= {1'b0, b_reg});
        quotient  = {q_reg[N-2:0], fits};
        remainder = fits ? N'(partial - {1'b0, b_reg}) : partial[N-1:0];
        done      = busy && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            q_reg <= '0;
            r_reg <= '0;
            b_reg <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            q_reg <= a;
            r_reg <= '0;
            b_reg <= b;
        end else if (busy) begin
            q_reg <= quotient;
            r_reg <= remainder;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU: single-cycle ops complete on the accepting edge, Mult/Div/Mod iterate N clocks.
// Results and flags are registered and only change on a completion edge.
module alu_seq
    import OpCodeEnum::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  OpCode        op,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic         Z,
    output logic         Nf,
    output logic         V,
    output logic         Cout,
    output logic         dz
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] SHIFT_LIMIT = N'(N);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    alu_seq_state_t state, state_next;

    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_reg, b_reg;
    OpCode          op_reg;
    logic [2*N-1:0] mul_acc, mul_sum, mul_prod;
    logic [N-1:0]   mul_mcand, mul_mplier;

    logic           accept, is_divmod, b_zero, div_start;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   div_q, div_r, div_q_s, div_r_s;
    logic           div_done;

    logic [N:0]     sum, diff;
    logic           load, flags_on;
    logic [N-1:0]   r_lo, r_hi;
    logic           r_z, r_n, r_v, r_c, r_dz;

    always_comb begin
        accept    = start && ready;
        is_divmod = (op == Div) || (op == Mod);
        b_zero    = (B == '0);
        div_start = accept && is_divmod && !b_zero;
        a_mag     = A[N-1] ? -A : A;
        b_mag     = B[N-1] ? -B : B;
    end

    seq_divider #(.N(N)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .a         (a_mag),
        .b         (b_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && op == Mult) begin
                    state_next = MUL;
                end else if (div_start) begin
                    state_next = DIV;
                end
            end
            MUL:     if (cnt == LAST) state_next = IDLE;
            DIV:     if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Shift-add works on magnitudes; the sign is restored once the last partial product is in.
    always_comb begin
        mul_sum  = mul_acc + (mul_mplier[cnt] ? ({{N{1'b0}}, mul_mcand} << cnt) : '0);
        mul_prod = (a_reg[N-1] ^ b_reg[N-1]) ? -mul_sum : mul_sum;
        div_q_s  = (a_reg[N-1] ^ b_reg[N-1]) ? -div_q : div_q;
        div_r_s  = a_reg[N-1] ? -div_r : div_r;
    end

    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};
        load     = 1'b0;
        flags_on = 1'b1;
        r_lo     = '0;
        r_hi     = '0;
        r_z      = 1'b0;
        r_n      = 1'b0;
        r_v      = 1'b0;
        r_c      = 1'b0;
        r_dz     = 1'b0;
        case (state)
            IDLE: begin
                load = accept && (op != Mult) && !div_start;
                case (op)
                    Add: begin
                        r_lo = sum[N-1:0];
                        r_c  = sum[N];
                        r_v  = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
                    end
                    Sub: begin
                        r_lo = diff[N-1:0];
                        r_c  = ~diff[N];
                        r_v  = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
                    end
                    And:    r_lo = A & B;
                    Or:     r_lo = A | B;
                    Xor:    r_lo = A ^ B;
                    LShift: r_lo = (B >= SHIFT_LIMIT) ? '0 : (A << B);
                    RShift: r_lo = (B >= SHIFT_LIMIT) ? {N{A[N-1]}} : $unsigned($signed(A) >>> B);
                    Div: begin
                        r_lo = '1;
                        r_dz = 1'b1;
                    end
                    Mod: begin
                        r_lo = A;
                        r_dz = 1'b1;
                    end
                    default: flags_on = 1'b0;
                endcase
                r_z = flags_on && (r_lo == '0);
                r_n = flags_on && r_lo[N-1];
            end
            MUL: begin
                load = (cnt == LAST);
                r_lo = mul_prod[N-1:0];
                r_hi = mul_prod[2*N-1:N];
                r_z  = (mul_prod == '0);
                r_n  = mul_prod[2*N-1];
                r_v  = (mul_prod != {{N{mul_prod[N-1]}}, mul_prod[N-1:0]});
            end
            DIV: begin
                load = div_done;
                if (op_reg == Div) begin
                    r_lo = div_q_s;
                    r_v  = (a_reg == MIN_VAL) && (b_reg == '1);
                end else begin
                    r_lo = div_r_s;
                end
                r_z = (r_lo == '0);
                r_n = r_lo[N-1];
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            out        <= '0;
            out_hi     <= '0;
            Z          <= 1'b0;
            Nf         <= 1'b0;
            V          <= 1'b0;
            Cout       <= 1'b0;
            dz         <= 1'b0;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= Add;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else begin
            done <= load;
            if (load) begin
                out    <= r_lo;
                out_hi <= r_hi;
                Z      <= r_z;
                Nf     <= r_n;
                V      <= r_v;
                Cout   <= r_c;
                dz     <= r_dz;
            end
            if (accept) begin
                a_reg      <= A;
                b_reg      <= B;
                op_reg     <= op;
                cnt        <= '0;
                mul_acc    <= '0;
                mul_mcand  <= a_mag;
                mul_mplier <= b_mag;
            end else if (state == MUL) begin
                mul_acc <= mul_sum;
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at N=4: an integer reference model queues expectations, completions pop them.
module tb_alu_seq;
    import OpCodeEnum::*;

    typedef struct {
        logic [3:0] out;
        logic [3:0] out_hi;
        logic       z;
        logic       nf;
        logic       v;
        logic       c;
        logic       dz;
        int         lat;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    OpCode      op = Add;
    logic       ready, done, Z, Nf, V, Cout, dz;
    logic [3:0] out, out_hi;

    expect_t sb[$];
    int nChecks = 0;
    int nFails = 0;

    alu_seq #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .op     (op),
        .ready  (ready),
        .done   (done),
        .out    (out),
        .out_hi (out_hi),
        .Z      (Z),
        .Nf     (Nf),
        .V      (V),
        .Cout   (Cout),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour in plain signed integer arithmetic.
    function automatic expect_t model(input logic [3:0] opv, input logic [3:0] av, input logic [3:0] bv);
        expect_t e;
        int sa, sb_, ua, ub, r, p;
        e = '{default: 0};
        e.lat = 1;
        sa = int'($signed(av));
        sb_ = int'($signed(bv));
        ua = int'(av);
        ub = int'(bv);
        r = 0;
        case (opv)
            4'd0: begin
                r = ua + ub;
                e.c = (r > 15);
                e.v = ((sa + sb_) > 7) || ((sa + sb_) < -8);
            end
            4'd1: begin
                r = ua - ub;
                e.c = (ua >= ub);
                e.v = ((sa - sb_) > 7) || ((sa - sb_) < -8);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (ub >= 4) ? 0 : (ua << ub);
            4'd6: r = (ub >= 4) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
            4'd7: begin
                p = sa * sb_;
                e.lat = 5;
                e.out = p[3:0];
                e.out_hi = p[7:4];
                e.z = (p == 0);
                e.nf = (p < 0);
                e.v = (p > 7) || (p < -8);
                return e;
            end
            4'd8: begin
                if (sb_ == 0) begin
                    r = -1;
                    e.dz = 1'b1;
                end else begin
                    r = sa / sb_;
                    e.v = (r > 7);
                    e.lat = 5;
                end
            end
            4'd9: begin
                if (sb_ == 0) begin
                    r = ua;
                    e.dz = 1'b1;
                end else begin
                    r = sa % sb_;
                    e.lat = 5;
                end
            end
            default: return e;
        endcase
        e.out = r[3:0];
        e.z = (e.out == 4'd0);
        e.nf = e.out[3];
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] opv, input logic [3:0] av, input logic [3:0] bv, input bit poke);
        expect_t e;
        int lat, busyLow;
        bit seen;
        sb.push_back(model(opv, av, bv));
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk); #1;
        end
        op = OpCode'(opv);
        A = av;
        B = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~av;
        B = ~bv;
        lat = 1;
        busyLow = 0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!ready) busyLow++;
                if (poke && lat == 2) begin
                    start = 1'b1;
                    op = Add;
                    A = 4'd1;
                    B = 4'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", lat, e.lat);
            checkOutput("busy_cycles", busyLow, e.lat - 1);
            checkOutput("out", out, e.out);
            checkOutput("out_hi", out_hi, e.out_hi);
            checkOutput("Z", Z, e.z);
            checkOutput("Nf", Nf, e.nf);
            checkOutput("V", V, e.v);
            checkOutput("Cout", Cout, e.c);
            checkOutput("dz", dz, e.dz);
            if (poke) begin
                @(posedge clk); #1;
                checkOutput("ignored_start_done", done, 1'b0);
                checkOutput("ignored_start_out", out, e.out);
            end
        end
    endtask

    task automatic abortMult();
        int dones;
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk); #1;
        end
        op = Mult;
        A = 4'b0011;
        B = 4'b1110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_out", out, 4'd0);
        checkOutput("abort_out_hi", out_hi, 4'd0);
        checkOutput("abort_flags", {Z, Nf, V, Cout, dz}, 5'd0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_ready", ready, 1'b1);
        #3;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_out", {out_hi, out}, 8'd0);
        checkOutput("reset_flags", {Z, Nf, V, Cout, dz}, 5'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4'd0, 4'b0111, 4'b0010, 1'b0);
        applyStimulus(4'd7, 4'b0011, 4'b1110, 1'b1);
        applyStimulus(4'd8, 4'b1000, 4'b0010, 1'b0);
        applyStimulus(4'd8, 4'b1000, 4'b1111, 1'b0);
        applyStimulus(4'd9, 4'b1001, 4'b0011, 1'b0);
        applyStimulus(4'd9, 4'b0111, 4'b0011, 1'b0);
        applyStimulus(4'd8, 4'b0110, 4'b0000, 1'b0);
        applyStimulus(4'd0, 4'b0011, 4'b0010, 1'b0);
        applyStimulus(4'd6, 4'b1100, 4'b0010, 1'b0);
        abortMult();
        applyStimulus(4'd1, 4'b0111, 4'b0101, 1'b0);
        applyStimulus(4'd5, 4'b0011, 4'b0101, 1'b0);
        applyStimulus(4'd6, 4'b1010, 4'b1001, 1'b0);
        applyStimulus(4'd9, 4'b1011, 4'b0000, 1'b0);
        applyStimulus(4'd7, 4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'd15, 4'b0101, 4'b0011, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle signed ALU: next generation of the combinational lab ALU, reusing its `OpCode` operation set. Adds registered results and flags, a start/ready/done handshake, iterative N-cycle signed multiply and divide/modulo, a full 2N-bit product, and divide-by-zero detection. Sits between the operand/opcode source (switch/FSM front end) and the display/flag logic; results hold stable until the next completion.

## Interface
- `N`, 4, operand width in bits, N ≥ 2
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; accepted only when `ready`=1
- `A`, `B`  in  N  signed operands, sampled on the accepting edge
- `op`  in  `OpCode`  operation, sampled on the accepting edge
- `ready`  out  1  high in IDLE
- `done`  out  1  one-cycle completion pulse
- `out`  out  N  result; low half of the product for Mult
- `out_hi`  out  N  high half of the product for Mult; 0 for all other ops
- `Z`, `Nf`, `V`, `Cout`  out  1 each  registered zero, negative, overflow and carry flags
- `dz`  out  1  divide-by-zero flag, Div/Mod only

## Operation
- States: IDLE, MUL, DIV. Iteration counter counts 0..N-1.
- Accepting edge E0: `start`=1 and `ready`=1. On E0, `A`, `B` and `op` are latched into internal registers.
- Single-cycle ops (Add, Sub, And, Or, Xor, LShift, RShift, unknown opcode): results and flags are registered on E0. State stays IDLE.
- Mult: E0 → MUL.
  - Shift-add on operand magnitudes, one bit per edge for N edges.
  - Sign fix-up (two's-complement negate) when operand signs differ.
  - `{out_hi,out}` = full signed 2N-bit product.
  - V=1 iff the product does not fit in N signed bits. Z/Nf are evaluated on the full 2N-bit product.
- Div/Mod: E0 → DIV.
  - Restoring division on magnitudes, N edges.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - B=0: no DIV state, completes like a single-cycle op. Div gives out = all ones, Mod gives out = A; dz=1, V=0.
  - Div of −2^(N-1) by −1: out = −2^(N-1), V=1.
- Flags:
  - Z = (result == 0). Nf = result MSB.
  - Add: Cout = unsigned carry-out; V = signed overflow.
  - Sub: Cout = no-borrow (A ≥ B unsigned); V = signed overflow.
  - Logic ops, shifts, Mod: V=0, Cout=0. Div: Cout=0.
  - `dz`=0 for every case except the B=0 Div/Mod case above.
- Shifts: amount = B taken as unsigned.
  - LShift is logical; an amount ≥ N gives 0.
  - RShift is arithmetic (sign fill); an amount ≥ N gives all sign bits.
- Unknown opcode: out=0, out_hi=0, all flags 0, still completes in one cycle.
- `start` while `ready`=0 is ignored; it is not queued.

## Timing
- Reset value of every output is 0, except `ready`=1. State returns to IDLE and the counter clears.
- A reset asserted mid-operation aborts it: no `done` pulse, outputs cleared.
- Single-cycle op: `done`, `out` and the flags are valid in the cycle after E0 (latency 1).
- Mult/Div/Mod (B≠0):
  - Iteration edges are E1..EN.
  - `ready`=0 from E0 until EN.
  - Results and `done` are registered on EN; `done` is high for the cycle after EN (latency N+1).
  - `ready` returns to 1 on EN.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- `out`, `out_hi` and the flags change only on completion edges. They hold between operations and during busy cycles.

## Structure
- The existing `OpCodeEnum` package supplies `OpCode`. Add to that package:
  - a 4-bit explicit encoding for `OpCode`
  - the `alu_seq_state_t` typedef (IDLE, MUL, DIV)
- Sub-module `seq_divider`, parametrised by N:
  - inputs: start, a, b magnitudes
  - outputs: quotient, remainder, done
  - `alu_seq` performs the sign handling and flag generation around it.
- The multiplier datapath is written inline.

## Test plan
- N=4, Add 0111+0010 → out 1001, V=1, Nf=1, Cout=0, Z=0; `done` exactly 1 cycle after E0.
- Mult 0011×1110 → `{out_hi,out}` = 11111010, Nf=1, V=0. `done` exactly 5 cycles after E0; `ready`=0 for 4 cycles. A `start` issued during busy is ignored.
- Div 1000/0010 → 1100. Div 1000/1111 → 1000 with V=1. Mod 1001%0011 → 1111. Mod 0111%0011 → 0001. Each has latency 5.
- Div 0110/0000 → out 1111, dz=1, latency 1. The following Add 0011+0010 → 0101 with dz=0.
- RShift 1100 by 0010 → 1111. LShift 0011 by 0101 → 0000 with Z=1. Unknown opcode → out 0, all flags 0.
- Assert `rst` on E2 of a Mult → all outputs 0 and `ready`=1 at once, no `done`. A following Sub 0111−0101 → 0010 with Cout=1.
